// File: rtl/generic_fifomn_reader_if.sv
// Bundle between the multi-pop FIFO, the reader and its single-beat consumer.
// master = the reader itself, slave = the FIFO/consumer environment around it.
interface generic_fifomn_reader_if #(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned FIFO_ENTRIES = 8,
  parameter int unsigned FIFO_ADDR    = (FIFO_ENTRIES == 1) ? 1 : $clog2(FIFO_ENTRIES),
  parameter int unsigned BUF_ENTRIES  = 4
);
  localparam int unsigned CNT_W = $clog2(BUF_ENTRIES + 1);

  logic [FIFO_ADDR:0]                   i_fifo_cnt;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]    i_fifo_data;
  logic [NUM_RD-1:0]                    o_fifo_pop;
  logic                                 i_flush;
  logic                                 o_valid;
  logic [DATA_WIDTH-1:0]                o_data;
  logic                                 i_ready;
  logic [CNT_W-1:0]                     o_buf_cnt;

  modport master (
    input  i_fifo_cnt, i_fifo_data, i_flush, i_ready,
    output o_fifo_pop, o_valid, o_data, o_buf_cnt
  );

  modport slave (
    output i_fifo_cnt, i_fifo_data, i_flush, i_ready,
    input  o_fifo_pop, o_valid, o_data, o_buf_cnt
  );
endinterface

// File: rtl/generic_fifomn_reader.sv
// Pops up to NUM_RD entries per cycle from a wide FIFO into a small circular
// holding buffer and drains it one entry per cycle on a valid/ready stream.
module generic_fifomn_reader #(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned FIFO_ENTRIES = 8,
  parameter int unsigned FIFO_ADDR    = (FIFO_ENTRIES == 1) ? 1 : $clog2(FIFO_ENTRIES),
  parameter int unsigned BUF_ENTRIES  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  generic_fifomn_reader_if.master bus
);

  localparam int unsigned PTR_W = (BUF_ENTRIES == 1) ? 1 : $clog2(BUF_ENTRIES);
  localparam int unsigned CNT_W = $clog2(BUF_ENTRIES + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned FC_W  = FIFO_ADDR + 1;

  logic [DATA_WIDTH-1:0] buf_q [BUF_ENTRIES];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      buf_cnt_q, buf_cnt_d;
  logic [FC_W-1:0]       fifo_cnt;
  logic [31:0]           npop;
  logic [NUM_RD-1:0]     pop_c;
  logic [PTR_W-1:0]      lane_idx [NUM_RD];
  logic                  deq;
  logic [SUM_W-1:0]      cnt_sum;

  // Compare-and-subtract wrap; operands stay below 2*BUF_ENTRIES so one step suffices.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                input logic [31:0] inc);
    logic [31:0] s;
    s = 32'(ptr) + inc;
    if (s >= 32'(BUF_ENTRIES)) s = s - 32'(BUF_ENTRIES);
    return PTR_W'(s);
  endfunction

  assign fifo_cnt = bus.i_fifo_cnt;

  // Pop count from registered occupancy only, so i_ready never reaches o_fifo_pop.
  always_comb begin
    npop = 32'(NUM_RD);
    if (32'(fifo_cnt) < npop) npop = 32'(fifo_cnt);
    if ((32'(BUF_ENTRIES) - 32'(buf_cnt_q)) < npop) npop = 32'(BUF_ENTRIES) - 32'(buf_cnt_q);
    if (i_reset || bus.i_flush) npop = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      pop_c[k]    = (32'(k) < npop);
      lane_idx[k] = wrap_add(wr_ptr_q, 32'(k));
    end
  end

  assign bus.o_fifo_pop = pop_c;
  assign bus.o_valid    = (buf_cnt_q != '0);
  assign bus.o_data     = bus.o_valid ? buf_q[rd_ptr_q] : '0;
  assign bus.o_buf_cnt  = buf_cnt_q;
  assign deq            = bus.o_valid & bus.i_ready;

  always_comb begin
    cnt_sum   = SUM_W'(buf_cnt_q) + SUM_W'(npop) - SUM_W'(deq);
    buf_cnt_d = CNT_W'(cnt_sum);
    rd_ptr_d  = deq ? wrap_add(rd_ptr_q, 32'd1) : rd_ptr_q;
    wr_ptr_d  = wrap_add(wr_ptr_q, npop);
    if (bus.i_flush) begin
      buf_cnt_d = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_cnt_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      buf_cnt_q <= buf_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Storage is left unreset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      if (pop_c[k]) buf_q[lane_idx[k]] <= bus.i_fifo_data[k];
    end
  end

endmodule

// File: tb/tb_generic_fifomn_reader.sv
// Directed bench: default-size reader for the hand-computed scenarios and a
// 3-deep instance streaming 0..9 against a small FIFO/occupancy model.
module tb_generic_fifomn_reader;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  generic_fifomn_reader_if #(.DATA_WIDTH(4), .NUM_RD(2), .FIFO_ENTRIES(8), .BUF_ENTRIES(4)) bus_a ();
  generic_fifomn_reader_if #(.DATA_WIDTH(4), .NUM_RD(2), .FIFO_ENTRIES(8), .BUF_ENTRIES(3)) bus_b ();

  generic_fifomn_reader #(.DATA_WIDTH(4), .NUM_RD(2), .FIFO_ENTRIES(8), .BUF_ENTRIES(4)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .bus(bus_a.master)
  );

  generic_fifomn_reader #(.DATA_WIDTH(4), .NUM_RD(2), .FIFO_ENTRIES(8), .BUF_ENTRIES(3)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .bus(bus_b.master)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus to instance A between clock edges.
  task automatic drive_a(input logic [3:0] cnt, input logic [3:0] d0, input logic [3:0] d1,
                         input logic rdy, input logic flush, input logic rst);
    @(negedge clk);
    bus_a.i_fifo_cnt     = cnt;
    bus_a.i_fifo_data[0] = d0;
    bus_a.i_fifo_data[1] = d1;
    bus_a.i_ready        = rdy;
    bus_a.i_flush        = flush;
    rst_a                = rst;
    #1;
  endtask

  task automatic expect_a(input string tag, input logic v, input logic [3:0] d, input logic [2:0] c);
    check_val({tag, "_valid"}, 32'(bus_a.o_valid), 32'(v));
    check_val({tag, "_data"},  32'(bus_a.o_data),  32'(d));
    check_val({tag, "_cnt"},   32'(bus_a.o_buf_cnt), 32'(c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fh, mcnt, nout, cnt, exp_np, free;
    logic rdy;
    logic [31:0] pat;

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.i_fifo_cnt = '0; bus_a.i_fifo_data = '0; bus_a.i_ready = 1'b0; bus_a.i_flush = 1'b0;
    bus_b.i_fifo_cnt = '0; bus_b.i_fifo_data = '0; bus_b.i_ready = 1'b0; bus_b.i_flush = 1'b0;

    // Reset state
    drive_a(4'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    check_val("rst_pop", 32'(bus_a.o_fifo_pop), 32'd0);
    drive_a(4'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b0;
    expect_a("rst", 1'b0, 4'h0, 3'd0);
    check_val("idle_pop", 32'(bus_a.o_fifo_pop), 32'd0);

    // Basic pop
    drive_a(4'd3, 4'hA, 4'hB, 1'b0, 1'b0, 1'b0);
    check_val("basic_pop", 32'(bus_a.o_fifo_pop), 32'd3);
    drive_a(4'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_a("basic", 1'b1, 4'hA, 3'd2);
    check_val("empty_fifo_pop", 32'(bus_a.o_fifo_pop), 32'd0);

    // Flush with three buffered entries
    drive_a(4'd1, 4'hC, 4'hD, 1'b0, 1'b0, 1'b0);
    check_val("one_pop", 32'(bus_a.o_fifo_pop), 32'd1);
    drive_a(4'd4, 4'hE, 4'hF, 1'b1, 1'b1, 1'b0);
    expect_a("pre_flush", 1'b1, 4'hA, 3'd3);
    check_val("flush_pop", 32'(bus_a.o_fifo_pop), 32'd0);
    drive_a(4'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_a("post_flush", 1'b0, 4'h0, 3'd0);
    drive_a(4'd1, 4'h5, 4'h6, 1'b0, 1'b0, 1'b0);
    check_val("refill_pop", 32'(bus_a.o_fifo_pop), 32'd1);
    drive_a(4'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    expect_a("refill", 1'b1, 4'h5, 3'd1);

    // Backpressure fill
    drive_a(4'd8, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
    expect_a("bp0", 1'b0, 4'h0, 3'd0);
    check_val("bp0_pop", 32'(bus_a.o_fifo_pop), 32'd3);
    drive_a(4'd8, 4'h3, 4'h4, 1'b0, 1'b0, 1'b0);
    expect_a("bp1", 1'b1, 4'h1, 3'd2);
    check_val("bp1_pop", 32'(bus_a.o_fifo_pop), 32'd3);
    drive_a(4'd8, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0);
    expect_a("bp2", 1'b1, 4'h1, 3'd4);
    check_val("bp2_pop", 32'(bus_a.o_fifo_pop), 32'd0);
    drive_a(4'd8, 4'h7, 4'h7, 1'b0, 1'b0, 1'b0);
    expect_a("bp3", 1'b1, 4'h1, 3'd4);
    check_val("bp3_pop", 32'(bus_a.o_fifo_pop), 32'd0);

    // Full with drain: freed slot is only usable the following cycle
    drive_a(4'd5, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0);
    expect_a("full0", 1'b1, 4'h1, 3'd4);
    check_val("full0_pop", 32'(bus_a.o_fifo_pop), 32'd0);
    drive_a(4'd5, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0);
    expect_a("full1", 1'b1, 4'h2, 3'd3);
    check_val("full1_pop", 32'(bus_a.o_fifo_pop), 32'd1);
    drive_a(4'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    expect_a("full2", 1'b1, 4'h3, 3'd3);
    drive_a(4'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    expect_a("drain0", 1'b1, 4'h4, 3'd2);
    drive_a(4'd0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    expect_a("drain1", 1'b1, 4'h5, 3'd1);

    // Reset mid-stream
    drive_a(4'd2, 4'h7, 4'h8, 1'b0, 1'b0, 1'b0);
    expect_a("mid0", 1'b0, 4'h0, 3'd0);
    check_val("mid0_pop", 32'(bus_a.o_fifo_pop), 32'd3);
    drive_a(4'd6, 4'h9, 4'hA, 1'b0, 1'b0, 1'b1);
    expect_a("mid1", 1'b1, 4'h7, 3'd2);
    check_val("mid_rst_pop", 32'(bus_a.o_fifo_pop), 32'd0);
    drive_a(4'd6, 4'h9, 4'hA, 1'b0, 1'b0, 1'b0);
    expect_a("post_rst", 1'b0, 4'h0, 3'd0);
    check_val("post_rst_pop", 32'(bus_a.o_fifo_pop), 32'd3);
    drive_a(4'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    expect_a("resume", 1'b1, 4'h9, 3'd2);

    // Wrap on the 3-deep instance: values 0..9 through a modelled FIFO
    fh = 0; mcnt = 0; nout = 0;
    pat = 32'hB3A5_6C9D;
    for (int cyc = 0; cyc < 200 && nout < 10; cyc++) begin
      @(negedge clk);
      cnt = (10 - fh > 8) ? 8 : 10 - fh;
      rdy = pat[cyc % 32];
      bus_b.i_fifo_cnt     = 4'(cnt);
      bus_b.i_fifo_data[0] = (fh < 10) ? 4'(fh) : 4'h0;
      bus_b.i_fifo_data[1] = (fh + 1 < 10) ? 4'(fh + 1) : 4'h0;
      bus_b.i_ready        = rdy;
      #1;
      free   = 3 - mcnt;
      exp_np = (cnt < 2) ? cnt : 2;
      if (free < exp_np) exp_np = free;
      check_val("wrap_pop", 32'(bus_b.o_fifo_pop), 32'((1 << exp_np) - 1));
      check_val("wrap_valid", 32'(bus_b.o_valid), 32'(mcnt != 0));
      if (mcnt != 0 && rdy) begin
        check_val("wrap_data", 32'(bus_b.o_data), 32'(nout));
        nout++;
        mcnt--;
      end
      fh   += exp_np;
      mcnt += exp_np;
    end
    check_val("wrap_total", 32'(nout), 32'd10);
    @(negedge clk);
    bus_b.i_fifo_cnt = '0;
    bus_b.i_ready    = 1'b0;
    #1;
    check_val("wrap_empty", 32'(bus_b.o_buf_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
